vc_link_arbiter: RTL

VC_LINK_ARBITER -- requirements
Module: vc_link_arbiter

---
 rtl/vc_link_arbiter_pkg.sv | 18 +
 rtl/vc_link_arbiter_rr_arbiter.sv | 26 ++
 rtl/vc_link_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/vc_link_arbiter_pkg.sv
// Shared flit-type encodings, parameter defaults and FSM state type for the VC link arbiter.
package vc_link_arbiter_pkg;

   localparam int NUM_VC_DEF   = 4;
   localparam int DATA_W_DEF   = 16;
   localparam int VC_DEPTH_DEF = 8;

   localparam logic [1:0] FT_BODY   = 2'b00;
   localparam logic [1:0] FT_HEAD   = 2'b01;
   localparam logic [1:0] FT_TAIL   = 2'b10;
   localparam logic [1:0] FT_SINGLE = 2'b11;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

endpackage

// File: rtl/vc_link_arbiter_rr_arbiter.sv
// Round-robin picker: one-hot grant to the first requester after 'last', wrapping; zero when no request.
// Purely combinational, no backpressure of its own.
module rr_arbiter #(
   parameter int NUM_VC = 4
) (
   input  logic [NUM_VC-1:0] req,
   input  logic [1:0]        last,
   output logic [NUM_VC-1:0] grant
);

   logic w_found;

   always_comb begin
      grant   = '0;
      w_found = 1'b0;
      for (int k = 1; k <= NUM_VC; k++) begin
         for (int j = 0; j < NUM_VC; j++) begin
            if (!w_found && req[j] && (j == (int'(last) + k) % NUM_VC)) begin
               grant[j] = 1'b1;
               w_found  = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/vc_link_arbiter.sv
// Merges NUM_VC credit-controlled virtual channels onto one link with packet locking; 1-cycle latency.
// Accepts a flit only when the output register is free and the VC has credit; holds output while stalled.
module vc_link_arbiter
   import vc_link_arbiter_pkg::*;
#(
   parameter int NUM_VC   = NUM_VC_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int VC_DEPTH = VC_DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_VC*DATA_W-1:0] vc_data_in,
   input  logic [NUM_VC-1:0]        vc_valid_in,
   output logic [NUM_VC-1:0]        vc_ready_in,
   output logic [DATA_W-1:0]        link_data,
   output logic [1:0]               link_vc,
   output logic                     link_valid,
   input  logic                     link_ready,
   input  logic                     credit_valid,
   input  logic [1:0]               credit_vc,
   output logic                     err_credit,
   output logic                     err_framing
);

   localparam int CW = $clog2(VC_DEPTH) + 1;

   logic [CW-1:0]     r_credit [NUM_VC];
   state_t            r_state;
   logic [1:0]        r_lock_vc;
   logic [1:0]        r_rr_ptr;
   logic              r_link_valid;
   logic [DATA_W-1:0] r_link_data;
   logic [1:0]        r_link_vc;
   logic              r_err_credit;
   logic              r_err_framing;

   logic              w_free;
   logic [NUM_VC-1:0] w_elig;
   logic [NUM_VC-1:0] w_req;
   logic [NUM_VC-1:0] w_grant;
   logic [NUM_VC-1:0] w_dec;
   logic [NUM_VC-1:0] w_inc;
   logic              w_xfer;
   logic [1:0]        w_xfer_vc;
   logic [DATA_W-1:0] w_xfer_dat;
   logic [1:0]        w_ftype;

   assign w_free = !r_link_valid || link_ready;

   always_comb begin
      w_elig = '0;
      w_inc  = '0;
      for (int i = 0; i < NUM_VC; i++) begin
         w_elig[i] = vc_valid_in[i] && (r_credit[i] != '0);
         w_inc[i]  = credit_valid && (credit_vc == 2'(i));
      end
   end

   // While a packet owns the link, only its VC may compete, even if it is credit-stalled.
   always_comb begin
      w_req = w_elig;
      if (r_state == ST_LOCKED) begin
         w_req = '0;
         for (int i = 0; i < NUM_VC; i++) begin
            if (2'(i) == r_lock_vc) w_req[i] = w_elig[i];
         end
      end
   end

   rr_arbiter #(.NUM_VC(NUM_VC)) u_rr_arbiter (
      .req   (w_req),
      .last  (r_rr_ptr),
      .grant (w_grant)
   );

   assign vc_ready_in = (rst || !w_free) ? '0 : w_grant;
   assign w_dec       = vc_ready_in & vc_valid_in;
   assign w_xfer      = |w_dec;

   always_comb begin
      w_xfer_vc  = '0;
      w_xfer_dat = '0;
      for (int i = 0; i < NUM_VC; i++) begin
         if (w_dec[i]) begin
            w_xfer_vc  = 2'(i);
            w_xfer_dat = vc_data_in[i*DATA_W +: DATA_W];
         end
      end
   end

   assign w_ftype = w_xfer_dat[DATA_W-1 -: 2];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_VC; i++) r_credit[i] <= CW'(VC_DEPTH);
         r_err_credit <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_VC; i++) begin
            if (w_dec[i] && !w_inc[i]) begin
               r_credit[i] <= r_credit[i] - CW'(1);
            end else if (w_inc[i] && !w_dec[i]) begin
               if (r_credit[i] == CW'(VC_DEPTH)) r_err_credit <= 1'b1;
               else                              r_credit[i]  <= r_credit[i] + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_lock_vc     <= '0;
         r_rr_ptr      <= 2'(NUM_VC - 1);
         r_err_framing <= 1'b0;
      end else if (w_xfer) begin
         case (r_state)
            ST_IDLE: begin
               r_rr_ptr <= w_xfer_vc;
               if (w_ftype == FT_HEAD) begin
                  r_state   <= ST_LOCKED;
                  r_lock_vc <= w_xfer_vc;
               end else if (w_ftype != FT_SINGLE) begin
                  r_err_framing <= 1'b1;
               end
            end
            ST_LOCKED: begin
               if (w_ftype == FT_TAIL)      r_state       <= ST_IDLE;
               else if (w_ftype != FT_BODY) r_err_framing <= 1'b1;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_link_valid <= 1'b0;
         r_link_data  <= '0;
         r_link_vc    <= '0;
      end else if (w_xfer) begin
         r_link_valid <= 1'b1;
         r_link_data  <= w_xfer_dat;
         r_link_vc    <= w_xfer_vc;
      end else if (link_ready) begin
         r_link_valid <= 1'b0;
      end
   end

   assign link_valid  = r_link_valid;
   assign link_data   = r_link_data;
   assign link_vc     = r_link_vc;
   assign err_credit  = r_err_credit;
   assign err_framing = r_err_framing;

endmodule
